in_port_fifo: RTL

- Parametrised successor to the data_path single-register input port.
- Captures words from an external device on an asynchronous strobe into a DEPTH-entry FIFO.
- Presents the oldest word to the bus mux input and pops it once per InPortout assertion.
- Adds strobe synchronisation, buffering, status flags, overflow detection and a threshold interrupt.

---
 rtl/io_pkg.sv | 12 +
 rtl/strobe_sync.sv | 28 ++
 rtl/in_port_fifo.sv | 112 +++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared I/O port defaults and sizing helpers.
package io_pkg;

  localparam int IO_WIDTH      = 32;
  localparam int IO_FIFO_DEPTH = 4;

  // Occupancy counter must hold the value DEPTH itself, hence one bit more than the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser plus edge flop: one-cycle pulse per rising edge of an asynchronous level.
module strobe_sync (
  input  logic clk_i,
  input  logic clear_i,
  input  logic async_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronise the asynchronous level and keep one extra stage for edge detection.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/in_port_fifo.sv
// Input port: captures device words on an asynchronous strobe into a FIFO read by the bus mux.
module in_port_fifo
  import io_pkg::*;
#(
  parameter int WIDTH      = IO_WIDTH,
  parameter int DEPTH      = IO_FIFO_DEPTH,
  parameter int IRQ_THRESH = 1
) (
  input  logic                     Clock,
  input  logic                     clear,
  input  logic                     strobe,
  input  logic [WIDTH-1:0]         input_data,
  input  logic                     InPortout,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         BusMuxInInPort,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             inport_prev_q;
  logic             push_req_s, pop_req_s;
  logic             do_push_s, do_pop_s;
  logic             empty_s, full_s;

  strobe_sync u_strobe_sync (
    .clk_i   (Clock),
    .clear_i (clear),
    .async_i (strobe),
    .pulse_o (push_req_s)
  );

  assign pop_req_s = InPortout & ~inport_prev_q;

  // Push/pop arbitration; a pop at full frees the slot the simultaneous push fills.
  always_comb begin
    empty_s    = (count_q == {CW{1'b0}});
    full_s     = (count_q == CW'(DEPTH));
    do_pop_s   = pop_req_s & ~empty_s;
    do_push_s  = push_req_s & (~full_s | do_pop_s);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push_req_s && !do_push_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      rd_ptr_q      <= {PW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
      overflow_q    <= 1'b0;
      inport_prev_q <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      inport_prev_q <= InPortout;
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge Clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= input_data;
    end
  end

  assign BusMuxInInPort = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
  assign empty          = empty_s;
  assign full           = full_s;
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign irq            = (count_q >= CW'(IRQ_THRESH));

endmodule
